// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its midpoint and
// presents each good byte with a one-cycle valid pulse or a framing-error pulse.
module uart_receiver #(
   parameter int CPB = 434,
   parameter int CW  = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = (CPB - 1) / 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA_BITS = 3'd2,
      STOP      = 3'd3,
      BREAK     = 3'd4
   } state_t;

   logic          sync1_q, sync2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    bit_index_q, bit_index_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;
   logic          rx_sync;

   assign rx_sync = sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= IDLE;
         count_q     <= '0;
         bit_index_q <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= rx;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         count_q     <= count_d;
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            count_d     = '0;
            bit_index_d = '0;
            if (!rx_sync) state_d = START;
         end
         START: begin
            count_d = count_q + 1'b1;
            if (count_q == CW'(HALF)) begin
               count_d     = '0;
               bit_index_d = '0;
               state_d     = rx_sync ? IDLE : DATA_BITS;
            end
         end
         DATA_BITS: begin
            count_d = count_q + 1'b1;
            if (count_q == CW'(CPB - 1)) begin
               shift_d[bit_index_q] = rx_sync;
               count_d              = '0;
               bit_index_d          = bit_index_q + 1'b1;
               if (bit_index_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            count_d = count_q + 1'b1;
            if (count_q == CW'(CPB - 1)) begin
               count_d = '0;
               if (rx_sync) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            count_d = '0;
            if (rx_sync) state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            count_d     = '0;
            bit_index_d = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated from the 8N1 line
// rules and the expected byte or framing error is queued for a separate monitor.
module tb_uart_receiver;

   localparam int CPB     = 434;
   localparam int LATENCY = 4126;

   typedef struct {
      bit         is_err;
      logic [7:0] byte_val;
      int         start_cyc;
      bit         timed;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   expect_t    exp_q[$];
   logic [7:0] model_data = 8'h00;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   uart_receiver #(.CPB(CPB), .CW(9)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   // Monitor: every output pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (valid || frame_err)) begin
         checkOutput("pulse_exclusive", int'(valid && frame_err), 0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", 1, 0);
         end else begin
            expect_t e;
            e = exp_q.pop_front();
            checkOutput("pulse_kind", int'(frame_err), int'(e.is_err));
            if (e.is_err) begin
               checkOutput("data_held_on_err", int'(data), int'(model_data));
            end else begin
               checkOutput("rx_data", int'(data), int'(e.byte_val));
               checkOutput("busy_falls_with_valid", int'(busy), 0);
               model_data = e.byte_val;
            end
            if (e.timed) checkRange("latency", cyc - e.start_cyc, LATENCY - 1, LATENCY + 1);
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one 8N1 frame with bit period p; rx is left at the stop level.
   task automatic sendFrame(input logic [7:0] b, input int p, input logic stop_lvl,
                            input bit timed);
      expect_t e;
      logic [9:0] bits;
      bits = {stop_lvl, b, 1'b0};
      @(posedge clk);
      #1;
      e.is_err    = !stop_lvl;
      e.byte_val  = b;
      e.start_cyc = cyc;
      e.timed     = timed;
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (p) @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus();
      logic [7:0] partial;
      int         gap;

      // reset state
      #1;
      checkOutput("reset_data", int'(data), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_valid", int'(valid), 0);
      waitCycles(5);
      rst = 1'b0;
      waitCycles(20);

      // single byte
      sendFrame(8'hA5, CPB, 1'b1, 1'b1);
      waitCycles(50);

      // back-to-back, no idle gap
      sendFrame(8'h00, CPB, 1'b1, 1'b1);
      sendFrame(8'hFF, CPB, 1'b1, 1'b1);
      sendFrame(8'h3C, CPB, 1'b1, 1'b1);
      waitCycles(50);

      // glitch: short low pulse must be rejected at the start-bit midpoint
      rx = 1'b0;
      waitCycles(100);
      rx = 1'b1;
      waitCycles(100);
      checkOutput("glitch_busy_mid", int'(busy), 1);
      waitCycles(40);
      checkOutput("glitch_busy_done", int'(busy), 0);
      waitCycles(50);

      // framing error followed by a held-low break
      sendFrame(8'h55, CPB, 1'b0, 1'b1);
      waitCycles(2000);
      checkOutput("break_busy", int'(busy), 1);
      rx = 1'b1;
      waitCycles(50);
      checkOutput("break_released", int'(busy), 0);
      sendFrame(8'h81, CPB, 1'b1, 1'b1);
      waitCycles(50);

      // reset during bit 4 of 0xC3
      partial = 8'hC3;
      @(posedge clk);
      #1;
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         waitCycles(CPB);
      end
      rx = partial[4];
      waitCycles(CPB / 2);
      checkOutput("busy_before_reset", int'(busy), 1);
      rst = 1'b1;
      #1;
      checkOutput("midreset_data", int'(data), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_valid", int'(valid), 0);
      checkOutput("midreset_ferr", int'(frame_err), 0);
      model_data = 8'h00;
      rx = 1'b1;
      waitCycles(10);
      rst = 1'b0;
      waitCycles(20);
      sendFrame(8'h7E, CPB, 1'b1, 1'b1);
      waitCycles(50);

      // baud tolerance: 2% fast then 2% slow
      sendFrame(8'h96, 425, 1'b1, 1'b0);
      waitCycles(200);
      sendFrame(8'h96, 443, 1'b1, 1'b0);
      waitCycles(200);

      // random bytes with random idle gaps
      for (int i = 0; i < 3; i++) begin
         gap = $urandom_range(0, 50);
         if (gap > 0) waitCycles(gap);
         sendFrame(8'($urandom), CPB, 1'b1, 1'b1);
      end
   endtask

   initial begin
      applyStimulus();
      waitCycles(5000);
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
